// File: rtl/alu_seq_if.sv
// Request/response bundle between the decode stage, the sequential ALU and writeback.
interface alu_seq_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       opcode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] alu;
    logic             flag_z;
    logic             flag_c;
    logic             flag_n;
    logic             flag_v;
    logic             busy;

    modport master (
        output in_valid, a, b, opcode, out_ready,
        input  in_ready, out_valid, alu, flag_z, flag_c, flag_n, flag_v, busy
    );

    modport slave (
        input  in_valid, a, b, opcode, out_ready,
        output in_ready, out_valid, alu, flag_z, flag_c, flag_n, flag_v, busy
    );
endinterface

// File: rtl/alu_seq.sv
// Handshaked ALU: single-cycle add/sub/logic/shift ops, WIDTH-cycle shift-add multiply.
// Result and flags are registered and held until the consumer takes them.
module alu_seq #(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH)
) (
    input logic       clk,
    input logic       rst_n,
    alu_seq_if.slave  bus
);
    localparam int M = WIDTH - 1;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_SHL = 3'd5;
    localparam logic [2:0] OP_SHR = 3'd6;
    localparam logic [2:0] OP_MUL = 3'd7;

    typedef enum logic [1:0] {IDLE, MULT, DONE} state_t;

    typedef struct packed {
        logic [WIDTH-1:0] alu;
        logic             z;
        logic             c;
        logic             n;
        logic             v;
    } rsp_t;

    state_t             state;
    logic               rdy_en;
    logic               out_valid_q;
    logic               busy_q;
    rsp_t               rsp_q;
    rsp_t               rsp_c;
    rsp_t               mul_rsp;
    logic [WIDTH:0]     wide;
    logic [2*WIDTH-1:0] mcand;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_nx;
    logic [WIDTH-1:0]   mplier;
    logic [SHW-1:0]     cnt;
    logic               accept;

    // rdy_en keeps in_ready low during reset and until the first edge after release.
    assign bus.in_ready = rdy_en && (state == IDLE || (state == DONE && bus.out_ready));
    assign accept       = bus.in_valid && bus.in_ready;

    // Single-cycle datapath; carries come from the WIDTH+1-bit intermediate.
    always_comb begin
        wide  = '0;
        rsp_c = '0;
        case (bus.opcode)
            OP_ADD: begin
                wide      = {1'b0, bus.a} + {1'b0, bus.b};
                rsp_c.alu = wide[M:0];
                rsp_c.c   = wide[WIDTH];
                rsp_c.v   = (bus.a[M] == bus.b[M]) && (wide[M] != bus.a[M]);
            end
            OP_SUB: begin
                wide      = {1'b0, bus.a} - {1'b0, bus.b};
                rsp_c.alu = wide[M:0];
                rsp_c.c   = wide[WIDTH];
                rsp_c.v   = (bus.a[M] != bus.b[M]) && (wide[M] != bus.a[M]);
            end
            OP_AND: rsp_c.alu = bus.a & bus.b;
            OP_OR:  rsp_c.alu = bus.a | bus.b;
            OP_XOR: rsp_c.alu = bus.a ^ bus.b;
            // Extra guard bit catches the last bit shifted out; b >= WIDTH+1 yields all zero.
            OP_SHL: begin
                wide      = {1'b0, bus.a} << bus.b;
                rsp_c.alu = wide[M:0];
                rsp_c.c   = wide[WIDTH];
            end
            OP_SHR: begin
                wide      = {bus.a, 1'b0} >> bus.b;
                rsp_c.alu = wide[WIDTH:1];
                rsp_c.c   = wide[0];
            end
            default: rsp_c = '0;
        endcase
        rsp_c.z = (rsp_c.alu == '0);
        rsp_c.n = rsp_c.alu[M];
    end

    always_comb begin
        acc_nx      = acc + (mplier[0] ? mcand : '0);
        mul_rsp     = '0;
        mul_rsp.alu = acc_nx[M:0];
        mul_rsp.c   = |acc_nx[2*WIDTH-1:WIDTH];
        mul_rsp.z   = (acc_nx[M:0] == '0);
        mul_rsp.n   = acc_nx[M];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            rdy_en      <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            rsp_q       <= '0;
            mcand       <= '0;
            acc         <= '0;
            mplier      <= '0;
            cnt         <= '0;
        end else begin
            rdy_en <= 1'b1;
            if (accept) begin
                if (bus.opcode == OP_MUL) begin
                    mcand       <= {{WIDTH{1'b0}}, bus.a};
                    mplier      <= bus.b;
                    acc         <= '0;
                    cnt         <= '0;
                    busy_q      <= 1'b1;
                    out_valid_q <= 1'b0;
                    state       <= MULT;
                end else begin
                    rsp_q       <= rsp_c;
                    out_valid_q <= 1'b1;
                    state       <= DONE;
                end
            end else begin
                case (state)
                    MULT: begin
                        acc    <= acc_nx;
                        mcand  <= mcand << 1;
                        mplier <= mplier >> 1;
                        cnt    <= cnt + 1'b1;
                        if (cnt == SHW'(WIDTH - 1)) begin
                            rsp_q       <= mul_rsp;
                            busy_q      <= 1'b0;
                            out_valid_q <= 1'b1;
                            state       <= DONE;
                        end
                    end
                    DONE: begin
                        if (bus.out_ready) begin
                            out_valid_q <= 1'b0;
                            state       <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.busy      = busy_q;
    assign bus.alu       = rsp_q.alu;
    assign bus.flag_z    = rsp_q.z;
    assign bus.flag_c    = rsp_q.c;
    assign bus.flag_n    = rsp_q.n;
    assign bus.flag_v    = rsp_q.v;
endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, handshaked successor to the combinational 8-bit CPU ALU.
- Accepts one operation at a time, a WIDTH-bit pair (a, b), and a 3-bit opcode.
- Returns a registered result plus status flags (zero, carry, negative, overflow).
- Adds a multi-cycle shift-add multiplier. Sits between the CPU decode stage and writeback, with valid/ready flow control on both sides.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range 4 to 32.
- SHW, $clog2(WIDTH), derived width of the shift-amount field; not to be overridden.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operation request.
- in_ready  output  1  block can accept a request this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- opcode  input  3  operation select.
- out_valid  output  1  result and flags are valid.
- out_ready  input  1  consumer accepts the result.
- alu  output  WIDTH  result.
- flag_z  output  1  result equals zero.
- flag_c  output  1  carry / borrow / shift-out / multiply-high-nonzero.
- flag_n  output  1  result MSB.
- flag_v  output  1  signed overflow (ADD/SUB only).
- busy  output  1  multiply in progress.

Behaviour:
- Reset (async, rst_n low):
  - State goes to IDLE.
  - out_valid=0, alu=0, all flags=0, busy=0, in_ready=0 while rst_n low; in_ready=1 from first clk edge after release.
  - Internal operand, accumulator and counter registers clear.
  - Reset mid-multiply aborts it with no output.
- Opcodes:
  - 000 ADD: a+b.
  - 001 SUB: a-b.
  - 010 AND.
  - 011 OR.
  - 100 XOR.
  - 101 SHL: a<<b.
  - 110 SHR, logical: a>>b.
  - 111 MUL: low WIDTH bits of unsigned a*b.
- Width rules:
  - All arithmetic is unsigned modulo 2^WIDTH.
  - Shifts: if b >= WIDTH, result is 0. Otherwise the shift amount is b[SHW-1:0].
- Flags:
  - ADD: c = carry-out. v = (a[MSB]==b[MSB]) && (alu[MSB]!=a[MSB]).
  - SUB: c = 1 when a<b unsigned (borrow). v = (a[MSB]!=b[MSB]) && (alu[MSB]!=a[MSB]).
  - SHL: c = last bit shifted out of the MSB end; 0 if b==0 or b>WIDTH.
  - SHR: c = last bit shifted out of the LSB end; 0 if b==0 or b>WIDTH.
  - MUL: c = 1 when the upper WIDTH bits of the full product are nonzero.
  - Logic ops: c=0.
  - v=0 for all ops except ADD and SUB.
  - z = (alu==0) and n = alu[MSB] for all ops.
- Handshake:
  - A request is accepted on a rising edge where in_valid && in_ready.
  - a, b and opcode are sampled only at accept; they are don't-care otherwise.
  - The result is consumed on a rising edge where out_valid && out_ready.
  - alu and flags hold stable while out_valid=1 and out_ready=0.
- States:
  - IDLE: in_ready=1.
    - Accepted non-MUL op: compute, register alu/flags, go to DONE.
    - Accepted MUL: latch operands, clear accumulator and counter, set busy, go to MULT.
  - MULT: in_ready=0, busy=1.
    - Each cycle adds the shifted multiplicand if the current multiplier bit is set; counter increments.
    - After WIDTH cycles, register result/flags, clear busy, go to DONE.
  - DONE: out_valid=1.
    - in_ready = out_ready, so a new op can be accepted in the same cycle the result is consumed.
    - On consume with no new accept: go to IDLE.
    - On consume with a new accept: behave as if accepted from IDLE; non-MUL stays in DONE with the new result.
- Latency:
  - Non-MUL: out_valid high on the edge after accept (1 cycle).
  - MUL: out_valid high WIDTH+1 edges after accept.
  - Back-to-back non-MUL ops with out_ready held high: one result per cycle.
- Boundary cases:
  - MUL by 0 runs the full WIDTH cycles; result 0, z=1.
  - in_valid during MULT is ignored (not accepted).
  - Opcode changes while out_valid=1 do not affect the held result.

Test Plan:
- WIDTH=8, a=0x11, b=0x82, ADD, out_ready=1 -> alu=0x93 after 1 cycle; z=0, c=0, n=1, v=0.
- Same operands, SUB -> alu=0x8F; c=1, n=1, v=1.
- Same operands, AND / OR / XOR -> alu=0x00 (z=1) / 0x93 / 0x93; c=0, v=0.
- Same operands, MUL -> busy=1 and in_ready=0 for 8 cycles; out_valid on the 9th edge; alu=0xA2, c=1, n=1. A concurrent in_valid is not accepted.
- SHL a=0x81, b=1 -> alu=0x02, c=1. SHL b=9 -> alu=0x00, z=1, c=0. SHR a=0x81, b=1 -> alu=0x40, c=1.
- Backpressure: hold out_ready=0 for 3 cycles after an ADD result -> alu/flags stable, in_ready=0. Raise out_ready together with a new in_valid (XOR 0xFF^0x0F) -> next cycle alu=0xF0.
- Pull rst_n low at cycle 4 of a MUL -> out_valid, busy and alu go to 0 immediately; after release, ADD 1+1 -> alu=0x02.
